// File: rtl/posit_round_norm_if.sv
// Bus bundle for the posit rounding stage: request fields in, rounded result out.
interface posit_round_norm_if #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned K_W   = 6,
    parameter int unsigned ES    = 3
) ();
    logic             start;
    logic [IN_W-1:0]  shifted_mantissa;
    logic [K_W-1:0]   k_in;
    logic [ES-1:0]    exp_in;
    logic             sign_in;
    logic [1:0]       rnd_mode;
    logic [OUT_W-1:0] mantissa_out;
    logic [K_W-1:0]   k_final;
    logic [ES-1:0]    exp_final;
    logic             sign_final;
    logic             inexact;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, shifted_mantissa, k_in, exp_in, sign_in, rnd_mode,
        input  mantissa_out, k_final, exp_final, sign_final, inexact, overflow, busy, done
    );

    modport slave (
        input  start, shifted_mantissa, k_in, exp_in, sign_in, rnd_mode,
        output mantissa_out, k_final, exp_final, sign_final, inexact, overflow, busy, done
    );
endinterface

// File: rtl/posit_round_norm.sv
// Posit rounding stage: truncates the normalised fraction with guard/sticky,
// applies the selected rounding mode, and ripples any carry into exp then k.
module posit_round_norm #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned K_W   = 6,
    parameter int unsigned ES    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    posit_round_norm_if.slave  rn
);
    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StRound    = 2'd1;
    localparam logic [1:0] StCarry    = 2'd2;
    localparam logic [1:0] StComplete = 2'd3;

    localparam logic [K_W-1:0] KMax = {1'b0, {(K_W-1){1'b1}}};

    logic [1:0]       state_q, state_d;
    logic             accept;

    // Captured request
    logic [IN_W-1:0]  sm_q;
    logic [K_W-1:0]   k_q;
    logic [ES-1:0]    exp_q;
    logic             sign_q;
    logic [1:0]       mode_q;

    // Rounded fraction with carry-out in the MSB
    logic [OUT_W:0]   sum_q, sum_d;
    logic             inexact_d;
    logic [OUT_W-1:0] trunc;
    logic             guard, sticky, inc;

    // Result registers
    logic [OUT_W-1:0] mant_q, mant_d;
    logic [K_W-1:0]   k_fin_q, k_fin_d;
    logic [ES-1:0]    exp_fin_q, exp_fin_d;
    logic             sign_fin_q;
    logic             inexact_q;
    logic             overflow_q, overflow_d;
    logic             done_q;

    assign accept = (state_q == StIdle) && rn.start;

    // Next-state: fixed four-step sequence, start only honoured in idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (rn.start) state_d = StRound;
            StRound:    state_d = StCarry;
            StCarry:    state_d = StComplete;
            StComplete: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Truncate, derive guard/sticky and the mode-dependent increment
    always_comb begin
        trunc  = sm_q[IN_W-1 -: OUT_W];
        guard  = sm_q[IN_W-OUT_W-1];
        sticky = |sm_q[IN_W-OUT_W-2:0];
        inc    = 1'b0;
        unique case (mode_q)
            2'b00:   inc = guard & (sticky | trunc[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = (guard | sticky) & ~sign_q;
            2'b11:   inc = (guard | sticky) & sign_q;
            default: inc = 1'b0;
        endcase
        sum_d     = {1'b0, trunc} + {{OUT_W{1'b0}}, inc};
        inexact_d = guard | sticky;
    end

    // Carry ripple: fraction -> exponent -> regime, saturating at KMax
    always_comb begin
        mant_d     = sum_q[OUT_W-1:0];
        exp_fin_d  = exp_q;
        k_fin_d    = k_q;
        overflow_d = 1'b0;
        if (sum_q[OUT_W]) begin
            if (!(&exp_q)) begin
                mant_d    = '0;
                exp_fin_d = exp_q + ES'(1);
            end else if (k_q == KMax) begin
                mant_d     = '1;
                exp_fin_d  = '1;
                k_fin_d    = KMax;
                overflow_d = 1'b1;
            end else begin
                mant_d    = '0;
                exp_fin_d = '0;
                k_fin_d   = k_q + K_W'(1);
            end
        end
    end

    // State, capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sm_q       <= '0;
            k_q        <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            mode_q     <= 2'b00;
            sum_q      <= '0;
            mant_q     <= '0;
            k_fin_q    <= '0;
            exp_fin_q  <= '0;
            sign_fin_q <= 1'b0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StComplete);
            if (accept) begin
                sm_q       <= rn.shifted_mantissa;
                k_q        <= rn.k_in;
                exp_q      <= rn.exp_in;
                sign_q     <= rn.sign_in;
                mode_q     <= rn.rnd_mode;
                inexact_q  <= 1'b0;
                overflow_q <= 1'b0;
            end
            if (state_q == StRound) begin
                sum_q     <= sum_d;
                inexact_q <= inexact_d;
            end
            if (state_q == StCarry) begin
                mant_q     <= mant_d;
                exp_fin_q  <= exp_fin_d;
                k_fin_q    <= k_fin_d;
                sign_fin_q <= sign_q;
                overflow_q <= overflow_d;
            end
        end
    end

    assign rn.mantissa_out = mant_q;
    assign rn.k_final      = k_fin_q;
    assign rn.exp_final    = exp_fin_q;
    assign rn.sign_final   = sign_fin_q;
    assign rn.inexact      = inexact_q;
    assign rn.overflow     = overflow_q;
    assign rn.busy         = (state_q != StIdle);
    assign rn.done         = done_q;
endmodule

// File: tb/tb_posit_round_norm.sv
// Bench for posit_round_norm: directed vectors with literal expectations plus a
// cycle-level reference model checked against the DUT on every falling edge.
module tb_posit_round_norm;
    localparam int unsigned IN_W  = 64;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned K_W   = 6;
    localparam int unsigned ES    = 3;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    posit_round_norm_if #(.IN_W(IN_W), .OUT_W(OUT_W), .K_W(K_W), .ES(ES)) rn ();

    posit_round_norm #(.IN_W(IN_W), .OUT_W(OUT_W), .K_W(K_W), .ES(ES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rn    (rn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: round as an integer division with remainder, then bump the
    // combined scale k*2^ES+exp on carry-out.
    typedef struct {
        logic [31:0] mant;
        int          k;
        int          e;
        bit          sg;
        bit          inx;
        bit          ovf;
    } res_t;

    function automatic res_t model(input logic [63:0] sm, input int k, input int e,
                                   input bit sg, input logic [1:0] md);
        res_t        r;
        logic [63:0] t, rem, half, v;
        bit          up;
        int          scale;
        t     = sm >> 32;
        rem   = sm & 64'h0000_0000_FFFF_FFFF;
        half  = 64'h0000_0000_8000_0000;
        r.inx = (rem != 0);
        r.sg  = sg;
        r.ovf = 1'b0;
        case (md)
            2'b00:   up = (rem > half) || ((rem == half) && t[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = r.inx && !sg;
            default: up = r.inx && sg;
        endcase
        v     = t + (up ? 64'd1 : 64'd0);
        r.k   = k;
        r.e   = e;
        r.mant = v[31:0];
        if (v == 64'h0000_0001_0000_0000) begin
            scale = k * 8 + e + 1;
            if (scale > 31 * 8 + 7) begin
                r.mant = 32'hFFFF_FFFF;
                r.k    = 31;
                r.e    = 7;
                r.ovf  = 1'b1;
            end else begin
                r.mant = 32'h0;
                r.k    = scale >>> 3;
                r.e    = scale & 7;
            end
        end
        return r;
    endfunction

    // Model timeline: age counts edges since the accepted start; -1 means idle
    int   m_age;
    res_t m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age      = -1;
            m_res.mant = '0;
            m_res.k    = 0;
            m_res.e    = 0;
            m_res.sg   = 1'b0;
            m_res.inx  = 1'b0;
            m_res.ovf  = 1'b0;
        end else if ((m_age < 0 || m_age == 3) && rn.start) begin
            m_age = 0;
            m_res = model(rn.shifted_mantissa, int'($signed(rn.k_in)), int'(rn.exp_in),
                          rn.sign_in, rn.rnd_mode);
        end else if (m_age >= 0 && m_age < 3) begin
            m_age = m_age + 1;
        end else begin
            m_age = -1;
        end
    end

    // Compare process: handshake every cycle, result fields whenever not busy
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(rn.busy), 64'(m_age >= 0 && m_age <= 2));
            chk("done", 64'(rn.done), 64'(m_age == 3));
            if (m_age < 0 || m_age == 3) begin
                chk("m_mant", 64'(rn.mantissa_out), 64'(m_res.mant));
                chk("m_k", 64'(rn.k_final), 64'(m_res.k[5:0]));
                chk("m_exp", 64'(rn.exp_final), 64'(m_res.e[2:0]));
                chk("m_sign", 64'(rn.sign_final), 64'(m_res.sg));
                chk("m_inexact", 64'(rn.inexact), 64'(m_res.inx));
                chk("m_overflow", 64'(rn.overflow), 64'(m_res.ovf));
            end
        end
    end

    task automatic drive(input logic [63:0] sm, input logic [5:0] k, input logic [2:0] e,
                         input bit sg, input logic [1:0] md);
        rn.shifted_mantissa = sm;
        rn.k_in             = k;
        rn.exp_in           = e;
        rn.sign_in          = sg;
        rn.rnd_mode         = md;
        rn.start            = 1'b1;
    endtask

    // One transaction with literal expectations and a bounded wait for done
    task automatic run(input string nm, input logic [63:0] sm, input logic [5:0] k,
                       input logic [2:0] e, input bit sg, input logic [1:0] md,
                       input logic [31:0] x_mant, input logic [5:0] x_k,
                       input logic [2:0] x_exp, input bit x_inx, input bit x_ovf);
        int n;
        @(negedge clk);
        drive(sm, k, e, sg, md);
        @(negedge clk);
        rn.start = 1'b0;
        n = 1;
        while (!rn.done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd4);
        chk({nm, "_mant"}, 64'(rn.mantissa_out), 64'(x_mant));
        chk({nm, "_k"}, 64'(rn.k_final), 64'(x_k));
        chk({nm, "_exp"}, 64'(rn.exp_final), 64'(x_exp));
        chk({nm, "_sign"}, 64'(rn.sign_final), 64'(sg));
        chk({nm, "_inexact"}, 64'(rn.inexact), 64'(x_inx));
        chk({nm, "_overflow"}, 64'(rn.overflow), 64'(x_ovf));
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        drive(64'h0, 6'd0, 3'd0, 1'b0, 2'b00);
        rn.start = 1'b0;
        #12;
        chk("rst_mant", 64'(rn.mantissa_out), 64'd0);
        chk("rst_done", 64'(rn.done), 64'd0);
        chk("rst_busy", 64'(rn.busy), 64'd0);
        chk("rst_flags", 64'({rn.inexact, rn.overflow, rn.k_final, rn.exp_final}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run("t1", 64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 3'd3, 1'b0, 2'b00,
            32'h0000_0000, 6'd2, 3'd4, 1'b1, 1'b0);
        run("t2_rne", 64'h1234_5678_ABCD_EF01, 6'd5, 3'd0, 1'b0, 2'b00,
            32'h1234_5679, 6'd5, 3'd0, 1'b1, 1'b0);
        run("t2_rtz", 64'h1234_5678_ABCD_EF01, 6'd5, 3'd0, 1'b0, 2'b01,
            32'h1234_5678, 6'd5, 3'd0, 1'b1, 1'b0);
        run("t3_odd", 64'h0000_0001_8000_0000, 6'd0, 3'd0, 1'b0, 2'b00,
            32'h0000_0002, 6'd0, 3'd0, 1'b1, 1'b0);
        run("t3_even", 64'h0000_0002_8000_0000, 6'd0, 3'd0, 1'b0, 2'b00,
            32'h0000_0002, 6'd0, 3'd0, 1'b1, 1'b0);
        run("t4_kneg", 64'hFFFF_FFFF_FFFF_FFFF, 6'h3F, 3'd7, 1'b0, 2'b00,
            32'h0000_0000, 6'd0, 3'd0, 1'b1, 1'b0);
        run("t4_sat", 64'hFFFF_FFFF_FFFF_FFFF, 6'd31, 3'd7, 1'b0, 2'b00,
            32'hFFFF_FFFF, 6'd31, 3'd7, 1'b1, 1'b1);
        run("t5_pinf", 64'h0000_0003_0000_0001, 6'd1, 3'd2, 1'b0, 2'b10,
            32'h0000_0004, 6'd1, 3'd2, 1'b1, 1'b0);
        run("t5_ninf_pos", 64'h0000_0003_0000_0001, 6'd1, 3'd2, 1'b0, 2'b11,
            32'h0000_0003, 6'd1, 3'd2, 1'b1, 1'b0);
        run("t5_ninf_neg", 64'h0000_0003_0000_0001, 6'd1, 3'd2, 1'b1, 2'b11,
            32'h0000_0004, 6'd1, 3'd2, 1'b1, 1'b0);
        for (int m = 0; m < 4; m++) begin
            run("t5_zero", 64'h0, 6'h3E, 3'd7, m[0], m[1:0],
                32'h0, 6'h3E, 3'd7, 1'b0, 1'b0);
        end

        // Start held high: one done per accepted start, every fourth edge
        @(negedge clk);
        drive(64'h0000_0005_C000_0000, 6'd3, 3'd1, 1'b1, 2'b00);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rn.done) dones++;
        end
        rn.start = 1'b0;
        chk("hold_dones", 64'(dones), 64'd3);
        chk("hold_mant", 64'(rn.mantissa_out), 64'h0000_0006);
        repeat (3) @(negedge clk);

        // Reset while in CARRY: no done, outputs cleared, next request is clean
        @(negedge clk);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 6'd4, 3'd2, 1'b0, 2'b00);
        @(negedge clk);
        rn.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_done", 64'(rn.done), 64'd0);
        chk("abort_busy", 64'(rn.busy), 64'd0);
        chk("abort_out", 64'({rn.mantissa_out, rn.k_final, rn.exp_final, rn.inexact}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rn.done) dones++;
        end
        chk("abort_nodone", 64'(dones), 64'd0);
        run("after_abort", 64'h1234_5678_ABCD_EF01, 6'd5, 3'd0, 1'b1, 2'b11,
            32'h1234_5679, 6'd5, 3'd0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
